mem_req_issuer: RTL and testbench
=================================

Name: mem_req_issuer

Overview:
- Request-side counterpart of the memory response FIFO in axi_to_mem. Takes word requests from upstream, presents them to the memory/bank port under a req/gnt handshake, and holds each request stable until it is granted.
- Limits in-flight requests with a credit counter sized to the downstream response FIFO. A response can therefore never arrive at a full FIFO.
- One request-hold register plus a credit counter. Sits between the AXI request decoder and the memory port.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, write data width. Must be a multiple of 8.
- STRB_WIDTH, DATA_WIDTH/8, byte-enable width. Derived; do not override.
- RESP_DEPTH, 8, depth of the downstream response FIFO and the maximum credits. Must be 1 or more.
- CNT_WIDTH, $clog2(RESP_DEPTH+1), width of the credit counter. Derived.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  synchronous clear of the hold register and credits
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request accepted this cycle
- req_addr_i  in  ADDR_WIDTH  request address
- req_we_i  in  1  write enable
- req_be_i  in  STRB_WIDTH  byte enables
- req_wdata_i  in  DATA_WIDTH  write data
- mem_req_o  out  1  memory request valid
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  ADDR_WIDTH  held address
- mem_we_o  out  1  held write enable
- mem_be_o  out  STRB_WIDTH  held byte enables
- mem_wdata_o  out  DATA_WIDTH  held write data
- resp_pop_i  in  1  response FIFO popped; returns one credit
- credits_o  out  CNT_WIDTH  number of reserved credits (credit_q)
- busy_o  out  1  credit_q != 0 or hold register valid
- underflow_o  out  1  sticky: resp_pop_i seen with credit_q == 0

Behaviour:
- Reset (rst_i high at a clock edge, overriding every other input):
  - hold_valid_q = 0, credit_q = 0, underflow_o = 0.
  - mem_req_o = 0, mem_addr/we/be/wdata_o = 0, busy_o = 0.
- flush_i (when not in reset): same clears as reset, except underflow_o keeps its value. The user issues flush only when memory is idle.
- States:
  - IDLE (hold_valid_q = 0).
  - WAIT_GNT (hold_valid_q = 1). mem_req_o = hold_valid_q and is registered; there is no combinational path from req_valid_i to mem_req_o.
- Accept condition:
  - accept = req_valid_i & req_ready_o.
  - req_ready_o = (!hold_valid_q | mem_gnt_i) & (credit_q < RESP_DEPTH).
  - resp_pop_i does not bypass into req_ready_o; a returned credit is usable one cycle later.
- On accept, the payload is captured into the hold register and hold_valid_q = 1 next cycle. Latency from accept to mem_req_o is 1 cycle.
- Grant:
  - A grant while hold_valid_q = 1 with no accept the same cycle moves the block to IDLE.
  - Grant and accept in the same cycle load the new payload and stay in WAIT_GNT. Back-to-back throughput is 1 request per cycle.
- Stability: while mem_req_o = 1 and mem_gnt_i = 0, mem_* outputs hold. An upstream change is ignored because req_ready_o = 0.
- mem_gnt_i while mem_req_o = 0 is ignored.
- Credits:
  - A credit is reserved on accept (+1) and released on resp_pop_i (-1).
  - Both in the same cycle leave credit_q unchanged.
  - credit_q saturates within 0..RESP_DEPTH.
  - A pop with credit_q = 0 leaves credit_q at 0 and sets underflow_o, which stays set until rst_i.
- Write requests consume a credit; every request is expected to produce one response.
- RESP_DEPTH = 1 degenerates to strictly one outstanding request.

Test Plan:
- Reset, then a single read (addr 0x100, we = 0): mem_req_o = 1 one cycle after accept. Drive gnt on cycle 3 → mem_addr_o stays 0x100 until the gnt; credits_o = 1. Pop → credits_o = 0 and busy_o = 0 next cycle.
- Continuous traffic, gnt always high, no pops, RESP_DEPTH = 8: exactly 8 accepts on consecutive cycles, then req_ready_o = 0 and credits_o = 8. One pop → exactly one more accept, starting the following cycle.
- Grant stall: gnt low for 5 cycles while upstream changes addr and data → mem_* outputs unchanged and req_ready_o = 0. Gnt high together with a new request → the next payload appears the next cycle with no bubble.
- Simultaneous accept and pop at credits_o = 5 → credits_o stays 5. Pop at credits_o = 0 → credits_o = 0 and underflow_o = 1, which stays set across a flush.
- rst_i asserted in WAIT_GNT with credits_o = 3 → next cycle mem_req_o = 0, credits_o = 0, underflow_o = 0. A flush in the same situation gives the same result, except underflow_o is retained.

Source files
------------

// File: rtl/mem_req_issuer.sv
// Request-side issuer for the memory port: holds each word request stable until granted
// and throttles in-flight requests with a credit counter sized to the response FIFO.
module mem_req_issuer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned RESP_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(RESP_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [STRB_WIDTH-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [STRB_WIDTH-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  resp_pop_i,
  output logic [CNT_WIDTH-1:0]  credits_o,
  output logic                  busy_o,
  output logic                  underflow_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CREDITS = CNT_WIDTH'(RESP_DEPTH);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  credit_q, credit_d;
  logic                  underflow_q, underflow_set;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [STRB_WIDTH-1:0] be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hold_valid;
  logic                  accept;
  logic                  load;

  assign hold_valid  = (state_q == WAIT_GNT);
  // A returned credit only becomes usable the cycle after the pop.
  assign req_ready_o = (!hold_valid || mem_gnt_i) && (credit_q < MAX_CREDITS);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT_GNT;
          load    = 1'b1;
        end
      end
      WAIT_GNT: begin
        if (accept) begin
          load = 1'b1;
        end else if (mem_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d      = credit_q;
    underflow_set = resp_pop_i && (credit_q == '0);
    case ({accept, resp_pop_i})
      2'b10:   credit_d = credit_q + CNT_WIDTH'(1);
      2'b01:   if (credit_q != '0) credit_d = credit_q - CNT_WIDTH'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Flush mirrors reset but keeps the sticky underflow flag for post-mortem inspection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      underflow_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      credit_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      if (underflow_set) underflow_q <= 1'b1;
      if (load) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        be_q    <= req_be_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  assign mem_req_o   = hold_valid;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign credits_o   = credit_q;
  assign busy_o      = (credit_q != '0) || hold_valid;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Directed bench for mem_req_issuer: per-cycle vector table plus hand sequences for
// credit exhaustion and grant stalls.
module tb_mem_req_issuer;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        resp_pop_i;
  logic [3:0]  credits_o;
  logic        busy_o;
  logic        underflow_o;

  int checks = 0;
  int errors = 0;

  mem_req_issuer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .resp_pop_i  (resp_pop_i),
    .credits_o   (credits_o),
    .busy_o      (busy_o),
    .underflow_o (underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        valid;
    logic [31:0] addr;
    logic        we;
    logic        gnt;
    logic        pop;
    logic        chk_ready;
    logic        exp_ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_credits;
    logic        exp_busy;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic flush, logic valid, logic [31:0] addr,
                              logic we, logic gnt, logic pop, logic chk_ready,
                              logic exp_ready, logic exp_req, logic [31:0] exp_addr,
                              logic exp_we, logic [3:0] exp_credits, logic exp_busy,
                              logic exp_uf);
    vec_t v;
    v.rst = rst; v.flush = flush; v.valid = valid; v.addr = addr; v.we = we;
    v.gnt = gnt; v.pop = pop; v.chk_ready = chk_ready; v.exp_ready = exp_ready;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_we = exp_we;
    v.exp_credits = exp_credits; v.exp_busy = exp_busy; v.exp_uf = exp_uf;
    return v;
  endfunction

  // Payload side-fields are derived from the address so held data can be checked too.
  function automatic logic [31:0] wdata_of(logic [31:0] a);
    return a * 32'd3;
  endfunction

  function automatic logic [3:0] be_of(logic [31:0] a);
    return a[5:2];
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic rst, logic flush, logic valid, logic [31:0] addr,
                               logic we, logic gnt, logic pop);
    @(negedge clk_i);
    rst_i       = rst;
    flush_i     = flush;
    req_valid_i = valid;
    req_addr_i  = addr;
    req_we_i    = we;
    req_be_i    = be_of(addr);
    req_wdata_i = wdata_of(addr);
    mem_gnt_i   = gnt;
    resp_pop_i  = pop;
  endtask

  task automatic runVector(int idx, vec_t v);
    applyStimulus(v.rst, v.flush, v.valid, v.addr, v.we, v.gnt, v.pop);
    #1;
    if (v.chk_ready) checkOutput($sformatf("v%0d ready", idx), 32'(req_ready_o), 32'(v.exp_ready));
    @(posedge clk_i);
    #1;
    checkOutput($sformatf("v%0d mem_req", idx), 32'(mem_req_o), 32'(v.exp_req));
    checkOutput($sformatf("v%0d addr", idx), mem_addr_o, v.exp_addr);
    checkOutput($sformatf("v%0d we", idx), 32'(mem_we_o), 32'(v.exp_we));
    checkOutput($sformatf("v%0d be", idx), 32'(mem_be_o), 32'(be_of(v.exp_addr)));
    checkOutput($sformatf("v%0d wdata", idx), mem_wdata_o, wdata_of(v.exp_addr));
    checkOutput($sformatf("v%0d credits", idx), 32'(credits_o), 32'(v.exp_credits));
    checkOutput($sformatf("v%0d busy", idx), 32'(busy_o), 32'(v.exp_busy));
    checkOutput($sformatf("v%0d underflow", idx), 32'(underflow_o), 32'(v.exp_uf));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int ready_after_pop;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    req_be_i = '0; req_wdata_i = '0; mem_gnt_i = 1'b0; resp_pop_i = 1'b0;

    //                 rst  fl   val  addr          we   gnt  pop  chkR rdy  req  exp_addr      we   cr  busy uf
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,4'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,4'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h100,      1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'h100,      1'b0,4'd1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h100,      1'b0,4'd1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,32'h100,      1'b0,4'd1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,      1'b0,4'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,      1'b0,4'd0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,4'd0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h200,      1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,32'h200,      1'b1,4'd1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h204,      1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,32'h204,      1'b1,4'd2,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h208,      1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,32'h208,      1'b1,4'd3,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h20C,      1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,32'h20C,      1'b1,4'd4,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h210,      1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,32'h210,      1'b1,4'd5,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h214,      1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h214,      1'b0,4'd5,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,32'h214,      1'b0,4'd5,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h214,      1'b0,4'd4,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h214,      1'b0,4'd3,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h300,      1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h300,      1'b0,4'd3,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,4'd0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h304,      1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,32'h304,      1'b1,4'd1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h308,      1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,32'h308,      1'b0,4'd2,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h30C,      1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,32'h30C,      1'b1,4'd3,1'b1,1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,4'd0,1'b0,1'b0));

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) runVector(i, vecs[i]);

    // Credit exhaustion: gnt and valid held high, no pops.
    doReset();
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("fill%0d ready", i), 32'(req_ready_o), (i < 8) ? 32'd1 : 32'd0);
      if (req_ready_o) accepts++;
      @(posedge clk_i);
      #1;
      if (i < 8) checkOutput($sformatf("fill%0d addr", i), mem_addr_o, 32'h1000 + 32'(i) * 32'd4);
    end
    checkOutput("fill accepts", 32'(accepts), 32'd8);
    checkOutput("fill credits", 32'(credits_o), 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("pop no bypass ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("pop credits", 32'(credits_o), 32'd7);
    ready_after_pop = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000 + 32'(i) * 32'd4, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("after pop%0d ready", i), 32'(req_ready_o), (i == 0) ? 32'd1 : 32'd0);
      if (req_ready_o) ready_after_pop++;
      @(posedge clk_i);
      #1;
    end
    checkOutput("after pop accepts", 32'(ready_after_pop), 32'd1);
    checkOutput("after pop credits", 32'(credits_o), 32'd8);
    checkOutput("after pop addr", mem_addr_o, 32'h2000);

    // Grant stall: upstream payload churns while the held request must stay put.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("stall first req", 32'(mem_req_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h540 + 32'(i) * 32'h40, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("stall%0d ready", i), 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("stall%0d req", i), 32'(mem_req_o), 32'd1);
      checkOutput($sformatf("stall%0d addr", i), mem_addr_o, 32'h500);
      checkOutput($sformatf("stall%0d wdata", i), mem_wdata_o, wdata_of(32'h500));
      checkOutput($sformatf("stall%0d we", i), 32'(mem_we_o), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("release ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("release req", 32'(mem_req_o), 32'd1);
    checkOutput("release addr", mem_addr_o, 32'h600);
    checkOutput("release we", 32'(mem_we_o), 32'd0);
    checkOutput("release credits", 32'(credits_o), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("drain req", 32'(mem_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
